// File: rtl/noc_input_router_vc.sv
// Per-input-port route stage: DOR route on head flits, stored per VC for body/tail (YX order under NOC_INPUT_ROUTER_YX_EN).
// Latency: 1 cycle from accept to flit_valid_o; single registered output stage.
// Backpressure: flit_ready_o = !flit_valid_o || flit_ready_i; output fields hold while stalled.
module noc_input_router_vc #(
    parameter int FLIT_WIDTH    = 37,
    parameter int X_WIDTH       = 2,
    parameter int Y_WIDTH       = 2,
    parameter int NUM_VC        = 2,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int ERR_CNT_WIDTH = 8,
    localparam int VC_WIDTH     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     flit_valid_i,
    output logic                     flit_ready_o,
    input  logic [FLIT_WIDTH-1:0]    flit_req_i,
    output logic                     flit_valid_o,
    input  logic                     flit_ready_i,
    output logic [FLIT_WIDTH-1:0]    flit_o,
    output logic [VC_WIDTH-1:0]      vc_o,
    output logic [4:0]               router_port_o,
    output logic                     err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic {IDLE, IN_PKT} vc_state_t;

    localparam logic [X_WIDTH-1:0]  RX       = X_WIDTH'(ROUTER_X);
    localparam logic [Y_WIDTH-1:0]  RY       = Y_WIDTH'(ROUTER_Y);
    localparam logic [VC_WIDTH:0]   NUM_VC_L = (VC_WIDTH+1)'(NUM_VC);

    localparam logic [4:0] P_LOCAL = 5'b00001;
    localparam logic [4:0] P_NORTH = 5'b00010;
    localparam logic [4:0] P_SOUTH = 5'b00100;
    localparam logic [4:0] P_WEST  = 5'b01000;
    localparam logic [4:0] P_EAST  = 5'b10000;

    vc_state_t state_q [NUM_VC];
    vc_state_t state_d [NUM_VC];
    logic [4:0] route_q [NUM_VC];
    logic [4:0] route_d [NUM_VC];

    logic                     out_vld_q;
    logic [FLIT_WIDTH-1:0]    flit_q;
    logic [VC_WIDTH-1:0]      vc_q;
    logic [4:0]               port_q;
    logic                     err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic [1:0]          ftype;
    logic [X_WIDTH-1:0]  x_dest;
    logic [Y_WIDTH-1:0]  y_dest;
    logic [VC_WIDTH-1:0] vc_id;
    logic                is_head, is_body, is_tail, is_ht, is_hdr;
    logic                vc_ok, accept, drop, err;
    vc_state_t           cur_state;
    logic [4:0]          stored_route, comp_route, fwd_route;

    assign ftype   = flit_req_i[FLIT_WIDTH-1 -: 2];
    assign x_dest  = flit_req_i[FLIT_WIDTH-3 -: X_WIDTH];
    assign y_dest  = flit_req_i[FLIT_WIDTH-3-X_WIDTH -: Y_WIDTH];
    assign vc_id   = flit_req_i[VC_WIDTH-1:0];
    assign is_head = (ftype == 2'b00);
    assign is_body = (ftype == 2'b01);
    assign is_tail = (ftype == 2'b10);
    assign is_ht   = (ftype == 2'b11);
    assign is_hdr  = is_head || is_ht;
    assign vc_ok   = ({1'b0, vc_id} < NUM_VC_L);

    assign flit_ready_o = !out_vld_q || flit_ready_i;
    assign accept       = flit_valid_i && flit_ready_o;

    always_comb begin
        comp_route = P_LOCAL;
`ifdef NOC_INPUT_ROUTER_YX_EN
        if (y_dest > RY)      comp_route = P_SOUTH;
        else if (y_dest < RY) comp_route = P_NORTH;
        else if (x_dest > RX) comp_route = P_EAST;
        else if (x_dest < RX) comp_route = P_WEST;
`else
        if (x_dest > RX)      comp_route = P_EAST;
        else if (x_dest < RX) comp_route = P_WEST;
        else if (y_dest > RY) comp_route = P_SOUTH;
        else if (y_dest < RY) comp_route = P_NORTH;
`endif
    end

    // Mux-select the addressed VC so an out-of-range id never indexes the arrays.
    always_comb begin
        cur_state    = IDLE;
        stored_route = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (vc_id == VC_WIDTH'(i)) begin
                cur_state    = state_q[i];
                stored_route = route_q[i];
            end
        end
    end

    assign drop      = !vc_ok || (cur_state == IDLE && (is_body || is_tail));
    assign err       = drop || (cur_state == IN_PKT && is_hdr);
    assign fwd_route = is_hdr ? comp_route : stored_route;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            state_d[i] = state_q[i];
            route_d[i] = route_q[i];
            if (accept && vc_ok && vc_id == VC_WIDTH'(i)) begin
                if (is_head || (is_ht && state_q[i] == IN_PKT)) route_d[i] = comp_route;
                if (is_head)                                    state_d[i] = IN_PKT;
                else if (is_ht || is_tail)                      state_d[i] = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                state_q[i] <= IDLE;
                route_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                state_q[i] <= state_d[i];
                route_q[i] <= route_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_vld_q <= 1'b0;
            flit_q    <= '0;
            vc_q      <= '0;
            port_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= accept && err;
            if (accept && err && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
            if (accept && !drop) begin
                out_vld_q <= 1'b1;
                flit_q    <= flit_req_i;
                vc_q      <= vc_id;
                port_q    <= fwd_route;
            end else if (flit_ready_i) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign flit_valid_o  = out_vld_q;
    assign flit_o        = flit_q;
    assign vc_o          = vc_q;
    assign router_port_o = out_vld_q ? port_q : 5'b00000;
    assign err_o         = err_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_noc_input_router_vc.sv
// Directed bench for noc_input_router_vc at router (1,1) with two VCs.
module tb_noc_input_router_vc;

    localparam int FW = 37;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          flit_valid_i = 1'b0;
    logic          flit_ready_o;
    logic [FW-1:0] flit_req_i = '0;
    logic          flit_valid_o;
    logic          flit_ready_i = 1'b1;
    logic [FW-1:0] flit_o;
    logic [0:0]    vc_o;
    logic [4:0]    router_port_o;
    logic          err_o;
    logic [7:0]    err_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    noc_input_router_vc #(
        .FLIT_WIDTH(FW), .X_WIDTH(2), .Y_WIDTH(2), .NUM_VC(2),
        .ROUTER_X(1), .ROUTER_Y(1), .ERR_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .arst(arst),
        .flit_valid_i(flit_valid_i), .flit_ready_o(flit_ready_o), .flit_req_i(flit_req_i),
        .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i), .flit_o(flit_o),
        .vc_o(vc_o), .router_port_o(router_port_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] x,
                                         input logic [1:0] y, input logic vc,
                                         input logic [29:0] pl);
        return {t, x, y, pl, vc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one flit for a single cycle and check the registered result.
    task automatic xfer(input string tag, input logic [FW-1:0] f, input logic exp_vld,
                        input logic [4:0] exp_port, input logic exp_err);
        flit_valid_i = 1'b1;
        flit_req_i   = f;
        step();
        chk({tag, ".vld"}, 64'(flit_valid_o), 64'(exp_vld));
        chk({tag, ".port"}, 64'(router_port_o), 64'(exp_port));
        chk({tag, ".err"}, 64'(err_o), 64'(exp_err));
        if (exp_vld) begin
            chk({tag, ".flit"}, 64'(flit_o), 64'(f));
            chk({tag, ".vc"}, 64'(vc_o), 64'(f[0]));
        end
    endtask

    task automatic idle(input string tag);
        flit_valid_i = 1'b0;
        step();
        chk({tag, ".vld0"}, 64'(flit_valid_o), 64'd0);
        chk({tag, ".port0"}, 64'(router_port_o), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".vld"}, 64'(flit_valid_o), 64'd0);
        chk({tag, ".flit"}, 64'(flit_o), 64'd0);
        chk({tag, ".vc"}, 64'(vc_o), 64'd0);
        chk({tag, ".port"}, 64'(router_port_o), 64'd0);
        chk({tag, ".err"}, 64'(err_o), 64'd0);
        chk({tag, ".cnt"}, 64'(err_cnt_o), 64'd0);
        chk({tag, ".rdy"}, 64'(flit_ready_o), 64'd1);
    endtask

    logic [FW-1:0] bp_head, bp_body, bp_tail;

    initial begin
        #1 arst = 1'b1;
        #1 chk_reset_outputs("rst");
        step();
        step();
        arst = 1'b0;

        // Single packet east on vc0
        xfer("p1.head", mk(2'b00, 2'd3, 2'd0, 1'b0, 30'h111), 1'b1, 5'b10000, 1'b0);
        xfer("p1.body", mk(2'b01, 2'd0, 2'd0, 1'b0, 30'h222), 1'b1, 5'b10000, 1'b0);
        xfer("p1.tail", mk(2'b10, 2'd0, 2'd0, 1'b0, 30'h333), 1'b1, 5'b10000, 1'b0);
        idle("p1.idle");

        // Interleaved VCs, then head-tail to self
        xfer("p2.h0",  mk(2'b00, 2'd1, 2'd3, 1'b0, 30'h401), 1'b1, 5'b00100, 1'b0);
        xfer("p2.h1",  mk(2'b00, 2'd0, 2'd1, 1'b1, 30'h402), 1'b1, 5'b01000, 1'b0);
        xfer("p2.b0",  mk(2'b01, 2'd3, 2'd3, 1'b0, 30'h403), 1'b1, 5'b00100, 1'b0);
        xfer("p2.t1",  mk(2'b10, 2'd3, 2'd3, 1'b1, 30'h404), 1'b1, 5'b01000, 1'b0);
        xfer("p2.t0",  mk(2'b10, 2'd0, 2'd0, 1'b0, 30'h405), 1'b1, 5'b00100, 1'b0);
        xfer("p2.ht",  mk(2'b11, 2'd1, 2'd1, 1'b0, 30'h406), 1'b1, 5'b00001, 1'b0);
        idle("p2.idle");

        // Backpressure hold then no-bubble release
        bp_head = mk(2'b00, 2'd2, 2'd1, 1'b1, 30'h501);
        bp_body = mk(2'b01, 2'd0, 2'd0, 1'b1, 30'h502);
        bp_tail = mk(2'b10, 2'd0, 2'd0, 1'b1, 30'h503);
        flit_ready_i = 1'b0;
        xfer("p3.head", bp_head, 1'b1, 5'b10000, 1'b0);
        flit_req_i = bp_body;
        for (int i = 0; i < 5; i++) begin
            chk("p3.rdy_lo", 64'(flit_ready_o), 64'd0);
            chk("p3.hold", 64'(flit_o), 64'(bp_head));
            step();
        end
        chk("p3.hold_vld", 64'(flit_valid_o), 64'd1);
        flit_ready_i = 1'b1;
        #1 chk("p3.rdy_hi", 64'(flit_ready_o), 64'd1);
        step();
        chk("p3.b2b_vld", 64'(flit_valid_o), 64'd1);
        chk("p3.b2b_flit", 64'(flit_o), 64'(bp_body));
        xfer("p3.tail", bp_tail, 1'b1, 5'b10000, 1'b0);
        idle("p3.idle");

        // Protocol errors
        xfer("p4.b_idle", mk(2'b01, 2'd0, 2'd0, 1'b1, 30'h601), 1'b0, 5'b00000, 1'b1);
        chk("p4.cnt1", 64'(err_cnt_o), 64'd1);
        idle("p4.idle");
        chk("p4.err_pulse", 64'(err_o), 64'd0);
        xfer("p4.h0",   mk(2'b00, 2'd3, 2'd0, 1'b0, 30'h602), 1'b1, 5'b10000, 1'b0);
        xfer("p4.h0b",  mk(2'b00, 2'd0, 2'd1, 1'b0, 30'h603), 1'b1, 5'b01000, 1'b1);
        chk("p4.cnt2", 64'(err_cnt_o), 64'd2);
        xfer("p4.b0",   mk(2'b01, 2'd3, 2'd3, 1'b0, 30'h604), 1'b1, 5'b01000, 1'b0);
        xfer("p4.ht0",  mk(2'b11, 2'd1, 2'd0, 1'b0, 30'h605), 1'b1, 5'b00010, 1'b1);
        xfer("p4.b_drop", mk(2'b01, 2'd0, 2'd0, 1'b0, 30'h606), 1'b0, 5'b00000, 1'b1);
        chk("p4.cnt4", 64'(err_cnt_o), 64'd4);
        flit_valid_i = 1'b1;
        flit_req_i   = mk(2'b01, 2'd0, 2'd0, 1'b1, 30'h607);
        repeat (251) step();
        flit_valid_i = 1'b0;
        step();
        chk("p4.cnt255", 64'(err_cnt_o), 64'd255);
        chk("p4.no_vld", 64'(flit_valid_o), 64'd0);
        flit_valid_i = 1'b1;
        repeat (50) step();
        flit_valid_i = 1'b0;
        step();
        chk("p4.sat", 64'(err_cnt_o), 64'd255);

        // Reset in the middle of a packet
        xfer("p5.head", mk(2'b00, 2'd3, 2'd1, 1'b0, 30'h701), 1'b1, 5'b10000, 1'b0);
        flit_valid_i = 1'b0;
        arst = 1'b1;
        #1 chk_reset_outputs("p5.rst");
        step();
        arst = 1'b0;
        xfer("p5.body", mk(2'b01, 2'd0, 2'd0, 1'b0, 30'h702), 1'b0, 5'b00000, 1'b1);
        chk("p5.cnt", 64'(err_cnt_o), 64'd1);
        idle("p5.idle");

        // Routing order on a diagonal destination
`ifdef NOC_INPUT_ROUTER_YX_EN
        xfer("p6.diag", mk(2'b11, 2'd3, 2'd3, 1'b1, 30'h801), 1'b1, 5'b00100, 1'b0);
`else
        xfer("p6.diag", mk(2'b11, 2'd3, 2'd3, 1'b1, 30'h801), 1'b1, 5'b10000, 1'b0);
`endif
        idle("p6.idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
